// File: rtl/scan_seq_pkg.sv
// Shared types and default sizes for the scan test sequencer.
package scan_seq_pkg;

  localparam int NUM_CHAINS_DEF = 7;
  localparam int CHAIN_LEN_DEF  = 32;
  localparam int PCW_DEF        = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/scan_seq_ctrl_if.sv
// Pattern-source side of the scan sequencer: control, word handshake and
// response stream. The comparator ports exist only when SCAN_SEQ_CMP_EN
// is defined.
interface scan_seq_ctrl_if import scan_seq_pkg::*; #(
  parameter int NUM_CHAINS = NUM_CHAINS_DEF,
  parameter int PCW        = PCW_DEF
) ();

  logic                  start;
  logic                  abort;
  logic [PCW-1:0]        pat_count;
  logic                  si_valid;
  logic                  si_ready;
  logic [NUM_CHAINS-1:0] si_data;
  logic                  so_valid;
  logic [NUM_CHAINS-1:0] so_data;
  logic                  busy;
  logic                  done;
`ifdef SCAN_SEQ_CMP_EN
  logic [NUM_CHAINS-1:0] exp_data;
  logic [15:0]           err_count;
  logic                  fail;

  modport master (
    output start, abort, pat_count, si_valid, si_data, exp_data,
    input  si_ready, so_valid, so_data, busy, done, err_count, fail
  );

  modport slave (
    input  start, abort, pat_count, si_valid, si_data, exp_data,
    output si_ready, so_valid, so_data, busy, done, err_count, fail
  );
`else
  modport master (
    output start, abort, pat_count, si_valid, si_data,
    input  si_ready, so_valid, so_data, busy, done
  );

  modport slave (
    input  start, abort, pat_count, si_valid, si_data,
    output si_ready, so_valid, so_data, busy, done
  );
`endif

endinterface

// File: rtl/scan_seq_cmp.sv
// Response comparator: checks each unloaded word against the expected word
// on the transfer edge, counts mismatching words (saturating) and keeps a
// sticky fail flag. Only instantiated when SCAN_SEQ_CMP_EN is defined.
module scan_seq_cmp import scan_seq_pkg::*; #(
  parameter int NUM_CHAINS = NUM_CHAINS_DEF
) (
  input  logic                  CK,
  input  logic                  RSTN,
  input  logic                  clear,
  input  logic                  sample,
  input  logic [NUM_CHAINS-1:0] resp,
  input  logic [NUM_CHAINS-1:0] exp_word,
  output logic [15:0]           err_count,
  output logic                  fail
);

  logic mismatch;

  assign mismatch = sample && (|(resp ^ exp_word));

  // Count mismatching words and latch the fail flag; a new run clears both
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      err_count <= '0;
      fail      <= 1'b0;
    end else if (clear) begin
      err_count <= '0;
      fail      <= 1'b0;
    end else if (mismatch) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      fail <= 1'b1;
    end
  end

endmodule

// File: rtl/scan_seq_ctrl.sv
// Scan test sequencer: runs pat_count+1 shift phases of CHAIN_LEN words
// (load-only, overlapped load/unload, unload-only) separated by one-cycle
// capture pulses, and streams unloaded response words on so_data.
// Optional build macro: SCAN_SEQ_CMP_EN adds the response comparator.
module scan_seq_ctrl import scan_seq_pkg::*; #(
  parameter int NUM_CHAINS = NUM_CHAINS_DEF,
  parameter int CHAIN_LEN  = CHAIN_LEN_DEF,
  parameter int PCW        = PCW_DEF
) (
  input  logic                  CK,
  input  logic                  RSTN,
  scan_seq_ctrl_if.slave        bus,
  output logic [NUM_CHAINS-1:0] SI_chain,
  input  logic [NUM_CHAINS-1:0] SO_chain,
  output logic                  scan_en,
  output logic                  test_en,
  output logic                  dut_ck_en
);

  localparam int             BCW      = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(CHAIN_LEN - 1);

  state_t                state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q;
  logic [PCW:0]          phase_q;
  logic [PCW-1:0]        pat_q;
  logic                  start_acc;
  logic                  xfer;
  logic                  word_end;
  logic                  last_phase;
  logic                  unload;
  logic                  so_valid_q;
  logic [NUM_CHAINS-1:0] so_data_q;

  assign start_acc  = (state_q == IDLE) && bus.start && !bus.abort;
  assign xfer       = (state_q == SHIFT) && bus.si_valid;
  assign word_end   = xfer && (bit_cnt_q == BIT_LAST);
  assign last_phase = (phase_q == {1'b0, pat_q});
  assign unload     = xfer && (phase_q != '0) && !bus.abort;

  assign test_en      = (state_q != IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.so_valid = so_valid_q;
  assign bus.so_data  = so_data_q;

  // State register
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and scan-side controls; abort overrides every transition
  always_comb begin
    state_d      = state_q;
    scan_en      = 1'b0;
    dut_ck_en    = 1'b0;
    bus.si_ready = 1'b0;
    bus.done     = 1'b0;
    SI_chain     = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = (bus.pat_count != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        scan_en      = 1'b1;
        bus.si_ready = 1'b1;
        dut_ck_en    = bus.si_valid;
        SI_chain     = last_phase ? '0 : bus.si_data;
        if (word_end) state_d = last_phase ? DONE : CAPTURE;
      end
      CAPTURE: begin
        dut_ck_en = 1'b1;
        state_d   = SHIFT;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  // Bit and phase counters advance only on word transfers
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      bit_cnt_q <= '0;
      phase_q   <= '0;
      pat_q     <= '0;
    end else if (start_acc) begin
      bit_cnt_q <= '0;
      phase_q   <= '0;
      pat_q     <= bus.pat_count;
    end else if (xfer) begin
      bit_cnt_q <= word_end ? '0 : bit_cnt_q + 1'b1;
      if (word_end) phase_q <= phase_q + 1'b1;
    end
  end

  // Register the unloaded response word; abort drops any pending word
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      so_valid_q <= 1'b0;
      so_data_q  <= '0;
    end else begin
      so_valid_q <= unload;
      if (bus.abort)   so_data_q <= '0;
      else if (unload) so_data_q <= SO_chain;
    end
  end

`ifdef SCAN_SEQ_CMP_EN
  scan_seq_cmp #(.NUM_CHAINS(NUM_CHAINS)) u_cmp (
    .CK        (CK),
    .RSTN      (RSTN),
    .clear     (start_acc),
    .sample    (unload),
    .resp      (SO_chain),
    .exp_word  (bus.exp_data),
    .err_count (bus.err_count),
    .fail      (bus.fail)
  );
`else
  // Without the comparator, responses are only streamed out on so_data
`endif

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Bench for scan_seq_ctrl with CHAIN_LEN=4: loopback chain model, response
// scoreboard, per-cycle vector table and hand-written corner sequences.
module tb_scan_seq_ctrl;
  import scan_seq_pkg::*;

  localparam int NC = 7;
  localparam int CL = 4;
  localparam int PW = 16;

  typedef struct {
    logic start;
    logic si_valid;
    logic scan_en;
    logic test_en;
    logic dut_ck_en;
    logic done;
    logic so_valid;
    logic [NC-1:0] so_data;
    logic si_pass;
  } vec_t;

  logic          CK = 1'b0;
  logic          RSTN = 1'b0;
  logic [NC-1:0] SI_chain;
  logic [NC-1:0] SO_chain;
  logic          scan_en, test_en, dut_ck_en;

  scan_seq_ctrl_if #(.NUM_CHAINS(NC), .PCW(PW)) sif ();

  scan_seq_ctrl #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .PCW(PW)) dut (
    .CK        (CK),
    .RSTN      (RSTN),
    .bus       (sif.slave),
    .SI_chain  (SI_chain),
    .SO_chain  (SO_chain),
    .scan_en   (scan_en),
    .test_en   (test_en),
    .dut_ck_en (dut_ck_en)
  );

  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;
  int err_word = -1;

  vec_t tbl[17];

  logic [NC-1:0] chain[CL];
  logic [NC-1:0] sb_q[$];
  logic          mon_en = 1'b0;
  int            mon_xfer, mon_so, mon_done, mon_pc;
  logic [63:0]   m_scan, m_test, m_ck, m_done, m_zero;

  // Loopback scan chains: shift when the DUT clock is enabled in scan mode
  always @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < CL; i++) chain[i] <= '0;
    end else if (dut_ck_en && scan_en) begin
      chain[0] <= SI_chain;
      for (int i = 1; i < CL; i++) chain[i] <= chain[i-1];
    end
  end

  assign SO_chain = chain[CL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Scoreboard: loaded words are queued, response words must come back in order
  always @(negedge CK) begin
    logic [NC-1:0] want;
    if (mon_en) begin
      if (sif.si_valid && sif.si_ready) begin
        if ((mon_xfer / CL) < mon_pc) sb_q.push_back(sif.si_data);
        mon_xfer++;
      end
      if (sif.so_valid) begin
        mon_so++;
        if (sb_q.size() == 0) begin
          check("so_unexpected", 32'd1, 32'd0);
        end else begin
          want = sb_q.pop_front();
          check("so_data_sb", 32'(sif.so_data), 32'(want));
        end
      end
      if (sif.done) mon_done++;
    end
  end

  task automatic check_output(input int c);
    string t;
    t = $sformatf("c%0d", c);
    check({t, "_scan_en"},   32'(scan_en),       32'(tbl[c].scan_en));
    check({t, "_test_en"},   32'(test_en),       32'(tbl[c].test_en));
    check({t, "_busy"},      32'(sif.busy),      32'(tbl[c].test_en));
    check({t, "_dut_ck_en"}, 32'(dut_ck_en),     32'(tbl[c].dut_ck_en));
    check({t, "_done"},      32'(sif.done),      32'(tbl[c].done));
    check({t, "_so_valid"},  32'(sif.so_valid),  32'(tbl[c].so_valid));
    check({t, "_si_chain"},  32'(SI_chain),      tbl[c].si_pass ? 32'(sif.si_data) : 32'd0);
    if (tbl[c].so_valid) check({t, "_so_data"}, 32'(sif.so_data), 32'(tbl[c].so_data));
  endtask

  task automatic apply_stimulus(input logic [PW-1:0] pc, input bit stall, input int abort_cyc,
                                input int ncyc, input bit use_tbl);
    int            drv_x;
    logic [NC-1:0] prev_si;
    drv_x    = 0;
    prev_si  = '0;
    sb_q.delete();
    mon_xfer = 0;
    mon_so   = 0;
    mon_done = 0;
    mon_pc   = int'(pc);
    m_scan   = '0;
    m_test   = '0;
    m_ck     = '0;
    m_done   = '0;
    m_zero   = '0;
    @(posedge CK); #1;
    mon_en = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      sif.pat_count = pc;
      sif.abort     = (c == abort_cyc);
      if (use_tbl) begin
        sif.start    = tbl[c].start;
        sif.si_valid = tbl[c].si_valid;
      end else begin
        sif.start    = (c == 0);
        sif.si_valid = stall ? (c % 2 == 1) : 1'b1;
      end
      if (sif.si_valid) begin
        sif.si_data = NC'(drv_x + 1);
`ifdef SCAN_SEQ_CMP_EN
        sif.exp_data = (drv_x >= CL) ? NC'(drv_x - CL + 1) : '1;
        if (drv_x == err_word) sif.exp_data[3] = ~sif.exp_data[3];
`endif
      end
      @(negedge CK);
      if (use_tbl) check_output(c);
      if (stall && !sif.si_valid && scan_en) begin
        check("stall_dut_ck_en", 32'(dut_ck_en), 32'd0);
        check("stall_si_hold",   32'(SI_chain),  32'(prev_si));
      end
      m_scan[c] = scan_en;
      m_test[c] = test_en;
      m_ck[c]   = dut_ck_en;
      m_done[c] = sif.done;
      m_zero[c] = !(scan_en | test_en | dut_ck_en | sif.si_ready | sif.busy | sif.done | sif.so_valid)
                  && (SI_chain == '0) && (sif.so_data == '0);
      if (sif.si_valid && sif.si_ready) drv_x++;
      prev_si = SI_chain;
      @(posedge CK); #1;
    end
    mon_en       = 1'b0;
    sif.start    = 1'b0;
    sif.abort    = 1'b0;
    sif.si_valid = 1'b0;
  endtask

  initial begin
    bit sh, cap;
    // Expected per-cycle behaviour for pat_count=2 with si_valid held high
    for (int c = 0; c < 17; c++) begin
      sh  = (c >= 1 && c <= 4) || (c >= 6 && c <= 9) || (c >= 11 && c <= 14);
      cap = (c == 5) || (c == 10);
      tbl[c].start     = (c == 0);
      tbl[c].si_valid  = 1'b1;
      tbl[c].scan_en   = sh;
      tbl[c].test_en   = (c >= 1 && c <= 15);
      tbl[c].dut_ck_en = sh || cap;
      tbl[c].done      = (c == 15);
      tbl[c].so_valid  = (c >= 7 && c <= 10) || (c >= 12 && c <= 15);
      tbl[c].so_data   = (c <= 10) ? NC'(c - 6) : NC'(c - 7);
      tbl[c].si_pass   = sh && (c <= 9);
    end

    sif.start     = 1'b0;
    sif.abort     = 1'b0;
    sif.pat_count = '0;
    sif.si_valid  = 1'b0;
    sif.si_data   = '0;
`ifdef SCAN_SEQ_CMP_EN
    sif.exp_data  = '0;
`endif

    // Reset state
    repeat (2) @(negedge CK);
    check("rst_ctrl", 32'({scan_en, test_en, dut_ck_en, sif.si_ready, sif.busy, sif.done, sif.so_valid}), 32'd0);
    check("rst_si_chain", 32'(SI_chain), 32'd0);
    check("rst_so_data", 32'(sif.so_data), 32'd0);
    RSTN = 1'b1;

    // pat_count = 0: straight to DONE
    apply_stimulus(16'd0, 1'b0, -1, 4, 1'b0);
    check("pc0_done", 32'(m_done[3:0]), 32'b0010);
    check("pc0_test_en", 32'(m_test[3:0]), 32'b0010);
    check("pc0_scan_en", 32'(m_scan[3:0]), 32'd0);
    check("pc0_dut_ck_en", 32'(m_ck[3:0]), 32'd0);

    // pat_count = 2, continuous data, vector table
    apply_stimulus(16'd2, 1'b0, -1, 17, 1'b1);
    check("full_xfers", 32'(mon_xfer), 32'd12);
    check("full_so_words", 32'(mon_so), 32'd8);
    check("full_done_cnt", 32'(mon_done), 32'd1);
    check("full_sb_left", 32'(sb_q.size()), 32'd0);

    // pat_count = 2, si_valid low every other cycle
    apply_stimulus(16'd2, 1'b1, -1, 28, 1'b0);
    check("stall_xfers", 32'(mon_xfer), 32'd12);
    check("stall_so_words", 32'(mon_so), 32'd8);
    check("stall_done_cnt", 32'(mon_done), 32'd1);
    check("stall_done_cyc", 32'(m_done[27:0]), 32'(1 << 24));

    // Abort in cycle 6
    apply_stimulus(16'd2, 1'b0, 6, 12, 1'b0);
    check("abort_busy_c6", 32'(m_zero[6]), 32'd0);
    check("abort_idle_c7", 32'(m_zero[7]), 32'd1);
    check("abort_no_done", 32'(m_done[11:0]), 32'd0);
    check("abort_no_so", 32'(mon_so), 32'd0);

    // Asynchronous reset in cycle 3
    apply_stimulus(16'd2, 1'b0, -1, 3, 1'b0);
    check("rstmid_pre_scan_en", 32'(scan_en), 32'd1);
    #2 RSTN = 1'b0;
    #1;
    check("rstmid_ctrl", 32'({scan_en, test_en, dut_ck_en, sif.si_ready, sif.busy, sif.done, sif.so_valid}), 32'd0);
    check("rstmid_si_chain", 32'(SI_chain), 32'd0);
    check("rstmid_so_data", 32'(sif.so_data), 32'd0);
    @(negedge CK);
    RSTN = 1'b1;

`ifdef SCAN_SEQ_CMP_EN
    // One response word differs in bit 3
    err_word = CL + 1;
    apply_stimulus(16'd2, 1'b0, -1, 17, 1'b1);
    check("cmp_err_count", 32'(sif.err_count), 32'd1);
    check("cmp_fail", 32'(sif.fail), 32'd1);
    err_word = -1;
    apply_stimulus(16'd0, 1'b0, -1, 3, 1'b0);
    check("cmp_clr_err_count", 32'(sif.err_count), 32'd0);
    check("cmp_clr_fail", 32'(sif.fail), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_seq_ctrl.md
# scan_seq_ctrl

Scan test sequencer for the scan-inserted s9234 core with seven scan chains. It accepts a stream of per-shift-cycle chain words, drives the shift/capture protocol (`scan_en`, `test_en`, a DUT clock enable, and `SI_chain*`), and returns the unloaded `SO_chain*` response words. It sits between a pattern source (a BIST/ATE buffer) and the `s9234_scan` instance. It replaces the free-running stimulus loop with a cycle-exact load/capture/unload schedule.

## Interface
- `NUM_CHAINS`, 7: number of scan chains (word width).
- `CHAIN_LEN`, 32: flops in the longest chain; shift cycles per load/unload.
- `PCW`, 16: width of the pattern counter.
- `CK` in 1: clock, rising edge.
- `RSTN` in 1: reset, asynchronous, active-low. One clock, no other reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `abort` in 1: synchronous abort; returns to IDLE next cycle.
- `pat_count` in PCW: number of patterns, latched on accepted `start`.
- `si_valid` / `si_ready` in/out 1: word handshake; a transfer occurs when both are high.
- `si_data` in NUM_CHAINS: bit i feeds chain i+1.
- `SI_chain` out NUM_CHAINS: to DUT scan inputs.
- `SO_chain` in NUM_CHAINS: from DUT scan outputs.
- `scan_en` out 1; `test_en` out 1; `dut_ck_en` out 1: clock-gate enable for the DUT clock.
- `so_valid` out 1; `so_data` out NUM_CHAINS: response words, no backpressure.
- `busy` out 1; `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, SHIFT, CAPTURE, DONE. Shift phases total `pat_count+1`: phase 0 is load-only, phases 1..pat_count-1 are overlapped load+unload, and the last phase is unload-only.
- IDLE: when `start` is high and `pat_count` is non-zero, go to SHIFT. When `start` is high and `pat_count` is 0, go to DONE. A `start` outside IDLE is ignored.
- SHIFT: `si_ready`=1. Each transfer advances the bit counter. After CHAIN_LEN transfers:
  - if all phases are done, go to DONE;
  - otherwise go to CAPTURE.
- The last phase still consumes CHAIN_LEN words. `si_data` is ignored in that phase and zeros are driven on `SI_chain`. Total words consumed is `(pat_count+1)*CHAIN_LEN`.
- CAPTURE: lasts 1 cycle, with `scan_en`=0 and `dut_ck_en`=1, then returns to SHIFT.
- DONE: `done`=1 for 1 cycle, then go to IDLE.
- Output rules:
  - `scan_en`=1 only in SHIFT.
  - `test_en` = `busy` = (state != IDLE).
  - `dut_ck_en` = (SHIFT && `si_valid`) || CAPTURE.
  - `SI_chain` = `si_data` (combinational) in SHIFT and not in the last phase; 0 otherwise.
- Stall: when `si_valid` is low in SHIFT, `dut_ck_en`=0. Chains hold and the counters hold.
- `abort` has priority over all transitions. It forces IDLE with no `done` pulse and discards the pending `so_valid`.
- Counters: the bit counter is `$clog2(CHAIN_LEN)` wide and wraps from CHAIN_LEN-1 to 0. The phase counter is PCW+1 bits, so `pat_count`=2^PCW-1 does not overflow.

## Timing
- Reset values: state IDLE; `scan_en`, `test_en`, `dut_ck_en`, `si_ready`, `busy`, `done`, `so_valid`=0; `SI_chain`, `so_data`=0. An asynchronous reset mid-shift takes effect immediately and no partial word is emitted.
- `start` accepted in cycle 0 gives SHIFT in cycle 1.
- `so_data` is a register of `SO_chain`, sampled on the edge of each transfer in phases ≥1. `so_valid` is high the cycle after that transfer (latency 1).
- The final `so_valid` coincides with the DONE cycle.

## Configuration
- `SCAN_SEQ_CMP_EN` defined:
  - adds input `exp_data[NUM_CHAINS]`, qualified by the same handshake, holding the expected response for the word being unloaded; it is ignored in phase 0;
  - adds outputs `err_count[15:0]` (saturating at 16'hFFFF; +1 per response word with any mismatching bit) and `fail` (sticky).
  - Both outputs clear on accepted `start` and on reset.
- Not defined: these ports and their logic are absent. Word counts are identical in both builds.

## Structure
- `scan_seq_pkg`: state enum, default NUM_CHAINS/CHAIN_LEN constants.
- Sub-module `scan_seq_cmp`, instantiated only under `SCAN_SEQ_CMP_EN`: registered XOR compare, error counter, sticky flag.

## Test plan
(NUM_CHAINS=7, CHAIN_LEN=4)
- `pat_count`=0, `start` in cycle 0 -> `done` in cycle 1; `scan_en` and `dut_ck_en` never high; `test_en` high only in cycle 1.
- `pat_count`=2, `si_valid` held high -> SHIFT in cycles 1-4, 6-9 and 11-14; CAPTURE in cycles 5 and 10; `done` in cycle 15; `so_valid` in cycles 7-10 and 12-15 (8 words); `SI_chain`=0 in cycles 11-14.
- Same setup with `si_valid` low every other cycle -> `dut_ck_en`=0 and `SI_chain` unchanged on stall cycles; exactly 12 transfers, 8 response words, 1 `done`.
- Load the chains via loopback (`SO_chain` = `SI_chain` delayed CHAIN_LEN) with words 7'h01..7'h04 -> the phase-1 `so_data` sequence is 7'h01..7'h04.
- `abort` in cycle 6 of `pat_count`=2 -> cycle 7 is IDLE, all outputs 0, no `done`. Deasserting `RSTN` in cycle 3 -> outputs 0 in the same cycle.
- With `SCAN_SEQ_CMP_EN`: `exp_data` differs from the response in bit 3 on one word -> `err_count`=1 and `fail`=1 at completion; a new `start` clears both.
